// File: rtl/modadd_sched_if.sv
// Requester/result bus between the modadd scheduler and its clients.
// The master side drives requests and the slave (scheduler) side drives grants and results.
interface modadd_sched_if #(
  parameter int NREQ = 2,
  parameter int LOGQ = 64,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*LOGQ-1:0] req_a;
  logic [NREQ*LOGQ-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [LOGQ-1:0]      res_c;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_c
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_c
  );
endinterface

// File: rtl/modadd_sched.sv
// Round-robin scheduler sharing one fixed-latency modadd among NREQ requesters; tags results
// with requester ID and sequences modulus changes (stop, drain, load, resume).
module modadd_sched #(
  parameter int NREQ = 2,
  parameter int LOGQ = 64,
  parameter int LAT  = 3,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [LOGQ-1:0] cfg_q,
  output logic            cfg_busy,
  modadd_sched_if.slave   bus,
  output logic [LOGQ-1:0] add_a,
  output logic [LOGQ-1:0] add_b,
  output logic [LOGQ-1:0] add_q,
  input  logic [LOGQ-1:0] add_c
);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_UNCFG, S_RUN, S_DRAIN, S_LOAD} state_t;

  state_t          state, state_nxt;
  logic [LOGQ-1:0] q_reg, q_pend;
  logic [IDW-1:0]  rr_ptr, gnt_id, idx;
  logic            gnt;
  logic [LAT-1:0]  tag_v;
  logic [IDW-1:0]  tag_id [LAT];
  logic [CW-1:0]   inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_UNCFG;
    else     state <= state_nxt;
  end

  // DRAIN checks the registered count, so it leaves one cycle after the last result.
  always_comb begin
    state_nxt = state;
    case (state)
      S_UNCFG: if (cfg_we) state_nxt = S_LOAD;
      S_RUN:   if (cfg_we) state_nxt = S_DRAIN;
      S_DRAIN: if (inflight == '0) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      default: state_nxt = S_UNCFG;
    endcase
  end

  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    idx    = '0;
    if (state == S_RUN && !cfg_we) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = IDW'((int'(rr_ptr) + k) % NREQ);
        if (!gnt && bus.req_valid[idx]) begin
          gnt    = 1'b1;
          gnt_id = idx;
        end
      end
    end
  end

  assign bus.req_ready = gnt ? (NREQ'(1) << gnt_id) : '0;
  assign add_a         = gnt ? bus.req_a[gnt_id*LOGQ +: LOGQ] : '0;
  assign add_b         = gnt ? bus.req_b[gnt_id*LOGQ +: LOGQ] : '0;
  assign add_q         = q_reg;
  assign cfg_busy      = (state != S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg  <= '0;
      q_pend <= '0;
      rr_ptr <= '0;
    end else begin
      if (cfg_we && (state == S_UNCFG || state == S_RUN)) q_pend <= cfg_q;
      if (state == S_LOAD) q_reg <= q_pend;
      if (gnt) rr_ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  // Tag pipe mirrors the modadd latency so the ID lines up with add_c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= gnt;
      tag_id[0] <= gnt_id;
      for (int s = 1; s < LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign bus.res_valid = tag_v[LAT-1];
  assign bus.res_id    = tag_id[LAT-1];
  assign bus.res_c     = add_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({gnt, bus.res_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_modadd_sched.sv
// Directed bench for modadd_sched with a behavioural fixed-latency modadd attached.
module tb_modadd_sched;
  localparam int NREQ = 2;
  localparam int LOGQ = 64;
  localparam int LAT  = 3;

  localparam logic [63:0] Q1  = 64'h1111100000000001;
  localparam logic [63:0] Q2  = 64'h0800000000000001;
  localparam logic [63:0] Q3  = 64'h0000000000000007;
  localparam logic [63:0] A0  = 64'h010000000000000A;
  localparam logic [63:0] B0  = 64'h1000000000000005;
  localparam logic [63:0] A1  = 64'h1000000000000000;
  localparam logic [63:0] B1  = 64'h1111000000000002;
  localparam logic [63:0] R0  = 64'h110000000000000F;
  localparam logic [63:0] R1  = 64'h0FFFF00000000001;
  localparam logic [63:0] R0N = 64'h090000000000000E;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [LOGQ-1:0] cfg_q;
  logic            cfg_busy;
  logic [LOGQ-1:0] add_a, add_b, add_q, add_c;
  logic [LOGQ-1:0] mp [LAT];

  int tests = 0;
  int fails = 0;

  modadd_sched_if #(.NREQ(NREQ), .LOGQ(LOGQ)) bus ();

  modadd_sched #(.NREQ(NREQ), .LOGQ(LOGQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_busy(cfg_busy),
    .bus(bus), .add_a(add_a), .add_b(add_b), .add_q(add_q), .add_c(add_c)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] madd(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] q);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[63:0];
  endfunction

  always @(posedge clk) begin
    mp[0] <= madd(add_a, add_b, add_q);
    for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
  end
  assign add_c = mp[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] t4_rdy  [11] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    logic       t4_busy [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       t4_rv   [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; cfg_we = 1'b0; cfg_q = '0;
    bus.req_valid = '0; bus.req_a = {A1, A0}; bus.req_b = {B1, B0};
    next_cycle();
    next_cycle();

    // Reset state
    @(negedge clk);
    chk("rst_busy", cfg_busy, 1);
    chk("rst_rdy", bus.req_ready, 0);
    chk("rst_rv", bus.res_valid, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_adda", add_a, 0);
    chk("rst_addb", add_b, 0);
    chk("rst_addq", add_q, 0);
    next_cycle();

    // T5: requests before any configuration are never granted
    rst = 1'b0;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5_rdy%0d", k), bus.req_ready, 0);
      chk($sformatf("t5_adda%0d", k), add_a, 0);
      chk($sformatf("t5_addb%0d", k), add_b, 0);
      chk($sformatf("t5_busy%0d", k), cfg_busy, 1);
      next_cycle();
    end

    // Configure Q1: UNCFG -> LOAD -> RUN
    cfg_we = 1'b1; cfg_q = Q1;
    @(negedge clk);
    chk("cfg_rdy", bus.req_ready, 0);
    next_cycle();
    cfg_we = 1'b0; bus.req_valid = 2'b00;
    @(negedge clk);
    chk("load_busy", cfg_busy, 1);
    chk("load_addq", add_q, 0);
    next_cycle();

    // T1: single op from requester 0
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("t1_busy", cfg_busy, 0);
    chk("t1_addq", add_q, Q1);
    chk("t1_rdy", bus.req_ready, 2'b01);
    chk("t1_adda", add_a, A0);
    chk("t1_addb", add_b, B0);
    next_cycle();
    bus.req_valid = 2'b00;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk($sformatf("t1_rv%0d", k), bus.res_valid, (k == LAT));
      if (k == LAT) begin
        chk("t1_id", bus.res_id, 0);
        chk("t1_c", bus.res_c, R0);
      end
      next_cycle();
    end

    // T2: single op from requester 1 (wraps modulo q)
    bus.req_valid = 2'b10;
    @(negedge clk);
    chk("t2_rdy", bus.req_ready, 2'b10);
    chk("t2_adda", add_a, A1);
    next_cycle();
    bus.req_valid = 2'b00;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk($sformatf("t2_rv%0d", k), bus.res_valid, (k == LAT));
      if (k == LAT) begin
        chk("t2_id", bus.res_id, 1);
        chk("t2_c", bus.res_c, R1);
      end
      next_cycle();
    end

    // T3: both requesters for 6 cycles, alternating grants and back-to-back results
    for (int k = 0; k < 6 + LAT + 1; k++) begin
      bus.req_valid = (k < 6) ? 2'b11 : 2'b00;
      @(negedge clk);
      chk($sformatf("t3_rdy%0d", k), bus.req_ready, (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      chk($sformatf("t3_rv%0d", k), bus.res_valid, (k >= LAT && k < 6 + LAT));
      if (k >= LAT && k < 6 + LAT) begin
        chk($sformatf("t3_id%0d", k), bus.res_id, (k - LAT) % 2);
        chk($sformatf("t3_c%0d", k), bus.res_c, ((k - LAT) % 2 == 0) ? R0 : R1);
      end
      next_cycle();
    end

    // T4: reconfigure mid-traffic; second cfg_we during DRAIN must be ignored
    for (int k = 0; k < 11; k++) begin
      bus.req_valid = (k < 8) ? 2'b11 : 2'b00;
      cfg_we = (k == 2 || k == 4);
      cfg_q  = (k == 2) ? Q2 : Q3;
      @(negedge clk);
      chk($sformatf("t4_rdy%0d", k), bus.req_ready, t4_rdy[k]);
      chk($sformatf("t4_busy%0d", k), cfg_busy, t4_busy[k]);
      chk($sformatf("t4_rv%0d", k), bus.res_valid, t4_rv[k]);
      if (k == 0) chk("t4_oldq", add_q, Q1);
      if (k == 7) begin
        chk("t4_newq", add_q, Q2);
        chk("t4_adda", add_a, A0);
      end
      if (k == 3) begin
        chk("t4_id3", bus.res_id, 0);
        chk("t4_c3", bus.res_c, R0);
      end
      if (k == 4) begin
        chk("t4_id4", bus.res_id, 1);
        chk("t4_c4", bus.res_c, R1);
      end
      if (k == 10) begin
        chk("t4_id10", bus.res_id, 0);
        chk("t4_c10", bus.res_c, R0N);
      end
      next_cycle();
    end
    cfg_we = 1'b0;

    // T6: reset with two ops in flight drops both results
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("t6_rdy0", bus.req_ready, 2'b10);
    next_cycle();
    @(negedge clk);
    chk("t6_rdy1", bus.req_ready, 2'b01);
    next_cycle();
    bus.req_valid = 2'b00;
    next_cycle();
    rst = 1'b1;
    #1;
    chk("t6_rv_rst", bus.res_valid, 0);
    chk("t6_busy_rst", cfg_busy, 1);
    chk("t6_addq_rst", add_q, 0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk($sformatf("t6_rv%0d", k), bus.res_valid, 0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
